// File: rtl/dma_controller.sv
`default_nettype none
// ==========================================================================
// dma_controller : copies device lines into data memory under BR/BG arbitration
// Revision       : 1.0
// ==========================================================================
module dma_controller #(
   parameter int WORD_SIZE    = 16,
   parameter int DEV_BIT_LEN  = 2,
   parameter int DEV_LINES    = 3,
   parameter int LINE_WORDS   = 4,
   parameter int WRITE_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     cmd_valid,
   input  logic [WORD_SIZE-1:0]     cmd_addr,
   input  logic [WORD_SIZE-1:0]     cmd_length,
   output logic                     cmd_ready,
   input  logic                     BG,
   output logic                     BR,
   output logic [DEV_BIT_LEN-1:0]   dev_offset,
   input  logic [4*WORD_SIZE-1:0]   dev_data,
   output logic                     mem_write,
   output logic [WORD_SIZE-1:0]     mem_addr,
   output logic [4*WORD_SIZE-1:0]   mem_wdata,
   output logic                     dma_end
);

   localparam int LINE_W = $clog2(DEV_LINES + 1);
   localparam int CYC_W  = 4;
   localparam int SHIFT  = $clog2(LINE_WORDS);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_REQ     = 3'd1;
   localparam logic [2:0] S_FETCH   = 3'd2;
   localparam logic [2:0] S_WRITE   = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [2:0]               state_q, state_d;
   logic [WORD_SIZE-1:0]     base_q, base_d;
   logic [LINE_W-1:0]        lines_q, lines_d;
   logic [LINE_W-1:0]        idx_q, idx_d;
   logic [CYC_W-1:0]         cyc_q, cyc_d;
   logic [4*WORD_SIZE-1:0]   line_buf_q, line_buf_d;
   logic [DEV_BIT_LEN-1:0]   dev_offset_q, dev_offset_d;

   logic [WORD_SIZE-1:0]     req_lines;
   logic [LINE_W-1:0]        cmd_lines;
   logic [LINE_W-1:0]        idx_inc;

   // Requested length in whole lines, clamped to what the device holds
   assign req_lines = cmd_length >> SHIFT;
   assign cmd_lines = (req_lines > WORD_SIZE'(DEV_LINES)) ? LINE_W'(DEV_LINES)
                                                          : req_lines[LINE_W-1:0];
   assign idx_inc   = idx_q + LINE_W'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         base_q       <= '0;
         lines_q      <= '0;
         idx_q        <= '0;
         cyc_q        <= '0;
         line_buf_q   <= '0;
         dev_offset_q <= '0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         lines_q      <= lines_d;
         idx_q        <= idx_d;
         cyc_q        <= cyc_d;
         line_buf_q   <= line_buf_d;
         dev_offset_q <= dev_offset_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      lines_d      = lines_q;
      idx_d        = idx_q;
      cyc_d        = cyc_q;
      line_buf_d   = line_buf_q;
      dev_offset_d = dev_offset;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               base_d  = cmd_addr;
               lines_d = cmd_lines;
               idx_d   = '0;
               cyc_d   = '0;
               state_d = (cmd_lines == '0) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (BG) state_d = S_FETCH;
         end
         S_FETCH: begin
            cyc_d = '0;
            if (!BG) begin
               state_d = S_REQ;
            end else begin
               line_buf_d = dev_data;
               state_d    = S_WRITE;
            end
         end
         S_WRITE: begin
            // A lost grant aborts the line; idx is kept so it is redone whole
            if (!BG) begin
               cyc_d   = '0;
               state_d = S_REQ;
            end else if (cyc_q == CYC_W'(WRITE_CYCLES - 1)) begin
               cyc_d   = '0;
               idx_d   = idx_inc;
               state_d = (idx_inc == lines_q) ? S_RELEASE : S_FETCH;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         S_RELEASE: begin
            if (!BG) state_d = S_DONE;
         end
         S_DONE: begin
            idx_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready  = (state_q == S_IDLE);
      BR         = (state_q == S_REQ) || (state_q == S_FETCH) || (state_q == S_WRITE);
      mem_write  = (state_q == S_WRITE);
      mem_addr   = mem_write ? (base_q + WORD_SIZE'(LINE_WORDS) * WORD_SIZE'(idx_q)) : '0;
      mem_wdata  = mem_write ? line_buf_q : '0;
      dma_end    = (state_q == S_DONE);
      dev_offset = (state_q == S_FETCH) ? DEV_BIT_LEN'(idx_q) : dev_offset_q;
   end

endmodule
`default_nettype wire

// File: doc/dma_controller.md
Name: dma_controller

Overview:
- Sequences the external storage device into data memory on behalf of the pipelined CPU.
- The CPU services the device interrupt, then issues one DMA command: destination base address and length in words.
- The controller requests the memory bus (BR/BG), walks device offsets 0..N-1, and writes each 64-bit line (4 x 16-bit words) to consecutive memory line addresses.
- It then releases the bus and pulses dma_end to interrupt the CPU.

Parameters:
WORD_SIZE, 16, width of one memory word and of addresses
DEV_BIT_LEN, 2, width of the device offset bus
DEV_LINES, 3, number of valid device storage lines; upper bound on lines per command
LINE_WORDS, 4, words per device line; address stride per line
WRITE_CYCLES, 4, cycles mem_write is held per line write; legal range 1..15

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  CPU issues a DMA command this cycle
cmd_addr  input  WORD_SIZE  destination base word address
cmd_length  input  WORD_SIZE  transfer length in words
cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
BG  input  1  bus grant from CPU
BR  output  1  bus request to CPU
dev_offset  output  DEV_BIT_LEN  line select to external device
dev_data  input  4*WORD_SIZE  line data from device, combinational in dev_offset
mem_write  output  1  memory write strobe (DMA side of bus)
mem_addr  output  WORD_SIZE  memory line address; 0 when mem_write low
mem_wdata  output  4*WORD_SIZE  write data; 0 when mem_write low
dma_end  output  1  one-cycle completion pulse to CPU

Behaviour:
- Reset (reset_n low, any state, immediate): state IDLE. BR, mem_write and dma_end are 0. dev_offset, mem_addr and mem_wdata are 0. Line and cycle counters are 0. Any in-flight transfer is abandoned; no partial line is written after reset rises.
- Line count: lines = min(cmd_length >> 2, DEV_LINES). cmd_length[1:0] is ignored.
- IDLE:
  - cmd_ready = 1.
  - On an accepted command, latch base = cmd_addr and lines.
  - If lines == 0: go to DONE; BR is never asserted.
  - Otherwise go to REQ.
  - cmd_valid in any other state is ignored; no queueing.
- REQ: BR = 1. When BG is sampled 1, go to FETCH with idx held from its previous value (0 on first entry).
- FETCH (1 cycle):
  - dev_offset = idx.
  - dev_data is registered into the line buffer at the clock edge.
  - Go to WRITE with cyc = 0.
- WRITE (WRITE_CYCLES cycles):
  - mem_write = 1, mem_addr = base + LINE_WORDS*idx (mod 2^WORD_SIZE, wraps silently), mem_wdata = line buffer.
  - cyc increments each cycle.
  - On the cycle with cyc == WRITE_CYCLES-1, the line is complete and idx increments.
  - If idx+1 == lines, go to RELEASE; else go to FETCH.
- BG revoked: if BG is sampled 0 in FETCH or WRITE, the current line is aborted.
  - mem_write drops next cycle and cyc resets to 0.
  - idx is unchanged, and the state returns to REQ with BR held 1.
  - When BG returns, the same line is re-fetched and rewritten from cyc 0.
- RELEASE: BR = 0. When BG is sampled 0, go to DONE.
- DONE (1 cycle): dma_end = 1, then IDLE. idx resets to 0.
- BR stays 1 continuously from REQ entry through the last WRITE cycle.
- mem_write is never 1 unless BG was 1 at the preceding edge.
- Latency:
  - Command accepted at edge E → BR = 1 in the cycle after E.
  - BG sampled 1 at edge G → first mem_write = 1 starts 2 cycles after G (FETCH, then WRITE).
  - Per-line cost is 1 + WRITE_CYCLES cycles.
- dev_offset holds its last value outside FETCH.

Test Plan:
- Basic 3-line transfer: reset, cmd_addr=0x01F4, cmd_length=12, BG=1 one cycle after BR.
  - Required: three write bursts, each with 4 mem_write cycles, at mem_addr 0x01F4, 0x01F8, 0x01FC.
  - Required: mem_wdata equals device lines 0, 1, 2.
  - Required: BR is high for exactly 1 + 15 + 1 cycles; dma_end pulses once after BG falls.
- Clamp and truncate: cmd_length=0x0013 → 3 lines. cmd_length=5 → 1 line at base only. cmd_length=3 → no BR; dma_end pulses 1 cycle after accept.
- Grant revoke: drop BG during the 2nd WRITE cycle of line 1 for 5 cycles.
  - Required: mem_write goes low and BR stays high.
  - Required: after BG returns, line 1 is rewritten in full (4 cycles) at base+4; line 2 follows; exactly one dma_end.
- Busy command: assert cmd_valid with different cmd_addr in REQ and WRITE.
  - Required: cmd_ready=0 and the transfer is unchanged.
  - Required: a new command right after dma_end is accepted.
- Async reset mid-WRITE: pull reset_n low between clock edges.
  - Required: BR, mem_write, mem_addr and dma_end are 0 immediately; no further writes after release.
  - Required: cmd_ready=1 on the first cycle after reset release.
- Address wrap: cmd_addr=0xFFF8, cmd_length=12 → mem_addr 0xFFF8, 0xFFFC, 0x0000.
